// File: rtl/wave_playback_ctrl.sv
// Waveform playback sequencer.
// A phase accumulator addresses the sine/triangle ROMs and the user RAM. The
// active waveform only changes on a period boundary, so the output never jumps
// mid-period. The single user-RAM port is shared between playback and host loads.
// Every source reaches the sample register exactly 2 clk after its phase value.
module wave_playback_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 7,
    parameter int PHASE_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [PHASE_W-1:0] tuning_word_i,
    input  logic [1:0]         wave_sel_i,
    input  logic               phase_sync_i,
    input  logic               ld_valid_i,
    input  logic [ADDR_W-1:0]  ld_addr_i,
    input  logic [DATA_W-1:0]  ld_data_i,
    output logic               ld_ready_o,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [DATA_W-1:0]  sin_data_i,
    input  logic [DATA_W-1:0]  tri_data_i,
    output logic [ADDR_W-1:0]  user_addr_o,
    output logic [DATA_W-1:0]  user_wdata_o,
    output logic               user_we_o,
    input  logic [DATA_W-1:0]  user_rdata_i,
    output logic [DATA_W-1:0]  sample_o,
    output logic               sample_valid_o,
    output logic               period_start_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [1:0] SEL_USER = 2'd2;

    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [1:0]         sel_q;
    logic               period_start_q;

    logic [PHASE_W:0]   phase_sum;
    logic               active;
    logic               wrap_ev;
    logic [ADDR_W-1:0]  phase_addr;
    logic               ld_accept;
    logic [DATA_W-1:0]  src_d;

    logic               valid1_q;
    logic [1:0]         sel1_q;
    logic [DATA_W-1:0]  rom1_q;
    logic [DATA_W-1:0]  sample_q;
    logic               sample_valid_q;

    assign phase_sum  = {1'b0, phase_q} + {1'b0, tuning_word_i};
    assign active     = (state_q != ST_IDLE);
    // phase_sync behaves like a natural wrap, but only while playing
    assign wrap_ev    = active & (phase_sum[PHASE_W] | phase_sync_i);
    assign phase_d    = phase_sync_i ? '0 : phase_sum[PHASE_W-1:0];
    assign phase_addr = phase_q[PHASE_W-1 -: ADDR_W];

    // Host loads are held off while the RAM is the live playback source;
    // reset drops any load presented in the same cycle.
    assign ld_ready_o   = !active || (sel_q != SEL_USER);
    assign ld_accept    = ld_valid_i & ld_ready_o & ~rst_i;
    assign user_we_o    = ld_accept;
    assign user_wdata_o = ld_data_i;
    assign user_addr_o  = ld_accept ? ld_addr_i : phase_addr;
    assign rom_addr_o   = phase_addr;

    // Source mux for ROM and square data; RAM data arrives already registered.
    always_comb begin
        src_d = '0;
        case (sel_q)
            2'd0:    src_d = sin_data_i;
            2'd1:    src_d = tri_data_i;
            2'd3:    src_d = {DATA_W{phase_q[PHASE_W-1]}};
            default: src_d = '0;
        endcase
    end

    // Playback FSM, phase accumulator and period-boundary waveform select.
    // A run=1 seen in STOPPING wins over a wrap in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            sel_q          <= 2'd0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= wrap_ev;
            if (!active || wrap_ev) begin
                sel_q <= wave_sel_i;
            end
            case (state_q)
                ST_IDLE: begin
                    phase_q <= '0;
                    if (run_i) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    phase_q <= phase_d;
                    if (!run_i) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (run_i) begin
                        state_q <= ST_RUN;
                        phase_q <= phase_d;
                    end else if (wrap_ev) begin
                        state_q <= ST_IDLE;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= '0;
                end
            endcase
        end
    end

    // Stage 1: delay ROM/square data to line up with the RAM read latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid1_q <= 1'b0;
            sel1_q   <= 2'd0;
            rom1_q   <= '0;
        end else begin
            valid1_q <= active;
            sel1_q   <= sel_q;
            rom1_q   <= src_d;
        end
    end

    // Stage 2: final sample; forced to zero when it did not come from playback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= valid1_q;
            if (!valid1_q) begin
                sample_q <= '0;
            end else if (sel1_q == SEL_USER) begin
                sample_q <= user_rdata_i;
            end else begin
                sample_q <= rom1_q;
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign period_start_o = period_start_q;

endmodule

// File: tb/tb_wave_playback_ctrl.sv
// Bench for wave_playback_ctrl: constant vector table, directed sequences for
// the multi-cycle corners, then random stimulus against a cycle-step model.
module tb_wave_playback_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] tw;
    logic [1:0]  wsel;
    logic        sync;
    logic        ldv;
    logic [6:0]  la;
    logic [6:0]  ld;
    logic        ld_ready;
    logic [6:0]  rom_addr;
    logic [6:0]  sin_data;
    logic [6:0]  tri_data;
    logic [6:0]  user_addr;
    logic [6:0]  user_wdata;
    logic        user_we;
    logic [6:0]  user_rdata;
    logic [6:0]  sample;
    logic        sample_valid;
    logic        period_start;

    wave_playback_ctrl #(.ADDR_W(7), .DATA_W(7), .PHASE_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .tuning_word_i(tw),
        .wave_sel_i(wsel), .phase_sync_i(sync), .ld_valid_i(ldv),
        .ld_addr_i(la), .ld_data_i(ld), .ld_ready_o(ld_ready),
        .rom_addr_o(rom_addr), .sin_data_i(sin_data), .tri_data_i(tri_data),
        .user_addr_o(user_addr), .user_wdata_o(user_wdata), .user_we_o(user_we),
        .user_rdata_i(user_rdata), .sample_o(sample),
        .sample_valid_o(sample_valid), .period_start_o(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: combinational ROMs and a registered-read user RAM.
    logic [6:0] sin_rom [128];
    logic [6:0] tri_rom [128];
    logic [6:0] ram     [128];
    logic       ram_clr;
    assign sin_data = sin_rom[rom_addr];
    assign tri_data = tri_rom[rom_addr];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 128; i++) ram[i] <= 7'd0;
        end else begin
            if (user_we) ram[user_addr] <= user_wdata;
            user_rdata <= ram[user_addr];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 playing, 2 finishing the current period
    typedef struct { bit v; int val; } pipe_t;
    int    m_mode, m_phase, m_sel;
    bit    m_ps, m_valid;
    int    m_sample;
    int    m_mem [128];
    pipe_t pq[$];

    function automatic int m_addr();
        return m_phase / 512;
    endfunction

    function automatic int src_val();
        case (m_sel)
            0: return int'(sin_rom[m_addr()]);
            1: return int'(tri_rom[m_addr()]);
            2: return m_mem[m_addr()];
            default: return (m_phase >= 32768) ? 127 : 0;
        endcase
    endfunction

    function automatic bit m_ready();
        return (m_mode == 0) || (m_sel != 2);
    endfunction

    task automatic model_update();
        pipe_t cur, o;
        bit act, ev;
        int sum, nxt;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_sel = 0;
            m_ps = 0; m_valid = 0; m_sample = 0;
            pq.delete();
            cur.v = 0; cur.val = 0;
            pq.push_back(cur);
        end else begin
            act = (m_mode != 0);
            sum = m_phase + int'(tw);
            ev  = act && (sum >= 65536 || sync);
            cur.v = act; cur.val = src_val();
            pq.push_back(cur);
            o = pq.pop_front();
            m_valid  = o.v;
            m_sample = o.v ? o.val : 0;
            m_ps     = ev;
            if (ldv && m_ready()) m_mem[la] = int'(ld);
            if (!act || ev) m_sel = int'(wsel);
            nxt = sync ? 0 : sum % 65536;
            case (m_mode)
                0: begin m_phase = 0; if (run) m_mode = 1; end
                1: begin m_phase = nxt; if (!run) m_mode = 2; end
                default: begin
                    if (run) begin m_mode = 1; m_phase = nxt; end
                    else if (ev) begin m_mode = 0; m_phase = 0; end
                    else m_phase = nxt;
                end
            endcase
        end
    endtask

    // Combinational outputs, checked with this cycle's inputs settled.
    task automatic step_pre();
        bit we;
        #1;
        we = ldv && m_ready() && !rst;
        chk("rom_addr", rom_addr, m_addr());
        chk("ld_ready", ld_ready, m_ready());
        chk("user_we", user_we, we);
        chk("user_addr", user_addr, we ? int'(la) : m_addr());
        if (we) chk("user_wdata", user_wdata, ld);
    endtask

    // Clock edge, then registered outputs.
    task automatic step_post();
        @(posedge clk);
        model_update();
        #1;
        chk("sample", sample, m_sample);
        chk("sample_valid", sample_valid, m_valid);
        chk("period_start", period_start, m_ps);
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic idle_inputs();
        run = 0; tw = 16'h0200; wsel = 0; sync = 0; ldv = 0; la = 0; ld = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        step(); step();
        rst = 0;
    endtask

    // Step until the model reaches a table address; expiry counts as a failure.
    task automatic run_to_addr(input int a);
        int n = 0;
        while (m_addr() != a && n < 400) begin step(); n++; end
        chk("reach_addr_in_budget", (n < 400), 1'b1);
    endtask

    typedef struct {
        bit       run; bit [1:0] sel; bit ldv; bit [6:0] la; bit [6:0] ld;
        int       e_rom; bit e_ready; bit e_we; bit e_valid;
    } vec_t;

    initial begin
        vec_t vt [7];
        int   cnt;
        rst = 1; ram_clr = 1; idle_inputs();
        for (int i = 0; i < 128; i++) begin
            sin_rom[i] = 7'($urandom_range(0, 127));
            tri_rom[i] = (i < 64) ? 7'(2 * i) : 7'(2 * (127 - i) + 1);
            m_mem[i] = 0;
        end
        repeat (2) @(posedge clk);
        model_update();
        #1;
        ram_clr = 0;
        rst = 0;
        chk("reset_sample", sample, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_pstart", period_start, 0);

        // Constant vectors from reset, tw=0x200.
        vt[0] = '{0, 2, 1, 5, 9,  0, 1, 1, 0};
        vt[1] = '{1, 2, 1, 6, 11, 0, 1, 1, 0};
        vt[2] = '{1, 2, 1, 7, 3,  0, 0, 0, 0};
        vt[3] = '{1, 2, 0, 0, 0,  1, 0, 0, 1};
        vt[4] = '{0, 2, 0, 0, 0,  2, 0, 0, 1};
        vt[5] = '{1, 0, 0, 0, 0,  3, 0, 0, 1};
        vt[6] = '{1, 0, 0, 0, 0,  4, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            run = vt[i].run; wsel = vt[i].sel; ldv = vt[i].ldv;
            la = vt[i].la; ld = vt[i].ld;
            step_pre();
            chk($sformatf("vec%0d_rom", i), rom_addr, vt[i].e_rom);
            chk($sformatf("vec%0d_ready", i), ld_ready, vt[i].e_ready);
            chk($sformatf("vec%0d_we", i), user_we, vt[i].e_we);
            step_post();
            chk($sformatf("vec%0d_valid", i), sample_valid, vt[i].e_valid);
        end

        // T1: sine at one address per clock; two wraps in 260 clk.
        do_reset();
        run = 1; tw = 16'h0200; wsel = 0;
        cnt = 0;
        for (int i = 0; i < 260; i++) begin step(); cnt += int'(period_start); end
        chk("t1_period_count", cnt, 2);

        // T2: ramp load in IDLE, then play the RAM.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            ldv = 1; la = 7'(i); ld = 7'(i);
            step_pre();
            chk("t2_load_ready", ld_ready, 1);
            step_post();
        end
        ldv = 0; wsel = 2; run = 1;
        repeat (10) step();
        chk("t2_ramp_sample", sample, m_addr() - 2);
        run_to_addr(60);

        // T3: loads stall while the RAM plays; select change lands at wrap.
        ldv = 1; la = 7'd3; ld = 7'd99; wsel = 1;
        cnt = 0;
        while (m_sel == 2 && cnt < 200) begin
            step_pre();
            chk("t3_no_write", user_we, 0);
            step_post();
            cnt++;
        end
        chk("t3_wrap_in_budget", (cnt < 200), 1'b1);
        step_pre();
        chk("t3_ready_after_wrap", ld_ready, 1);
        step_post();
        ldv = 0;

        // T4: stop at 40 finishes the period; re-raise at 100 keeps playing.
        do_reset();
        run = 1; wsel = 0; tw = 16'h0200;
        run_to_addr(40);
        run = 0;
        cnt = 0;
        while (m_mode != 0 && cnt < 200) begin step(); cnt++; end
        chk("t4_idle_in_budget", (cnt < 200), 1'b1);
        chk("t4_addr_after_stop", rom_addr, 0);
        step(); step();
        chk("t4_valid_fell", sample_valid, 0);
        run = 1;
        run_to_addr(40);
        run = 0;
        run_to_addr(100);
        run = 1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin step(); cnt += int'(sample_valid); end
        chk("t4_kept_running", cnt, 60);

        // T5: square wave then phase_sync.
        do_reset();
        run = 1; wsel = 3; tw = 16'h0400;
        repeat (70) step();
        run_to_addr(20);
        sync = 1;
        step();
        sync = 0;
        chk("t5_sync_pstart", period_start, 1);
        step_pre();
        chk("t5_sync_addr", rom_addr, 0);
        step_post();

        // T6: reset during STOPPING with a load pending.
        do_reset();
        run = 1; wsel = 1;
        repeat (30) step();
        run = 0;
        repeat (5) step();
        ldv = 1; la = 7'd9; ld = 7'd77; rst = 1;
        step_pre();
        chk("t6_we_in_reset", user_we, 0);
        step_post();
        step_pre();
        chk("t6_we_after", user_we, 0);
        chk("t6_rom_addr", rom_addr, 0);
        step_post();
        chk("t6_sample", sample, 0);
        chk("t6_valid", sample_valid, 0);
        rst = 0; ldv = 0;

        // Random stimulus against the model.
        do_reset();
        run = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 9))
                    0: tw = 16'h0000;
                    1: tw = 16'hFFFF;
                    2: tw = 16'h8000;
                    default: tw = 16'($urandom_range(16'h0080, 16'h1800));
                endcase
            end
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) wsel = 2'($urandom_range(0, 3));
            sync = ($urandom_range(0, 59) == 0);
            ldv  = 1'($urandom_range(0, 1));
            la   = 7'($urandom_range(0, 127));
            ld   = 7'($urandom_range(0, 127));
            rst  = ($urandom_range(0, 699) == 0);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
